rf_readport_arb: RTL and testbench

Register-read port arbiter between the issue-queue select stage and the IssueQ→RegRead pipeline latch.

- Each cycle up to four issue lanes present granted instructions. Each lane needs 0–2 physical register file read ports, and the RF has only `READ_PORTS` ports.
- The block decides which lanes proceed to RegRead this cycle and assigns each a contiguous read-port base.
- Lanes that do not fit are held internally. While any lane is held, the issue queue is stalled.
- Fairness comes from a rotating start pointer.

---
 rtl/rf_readport_arb.sv | 127 ++++++++++++
 tb/tb_rf_readport_arb.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/rf_readport_arb.sv
// Register-read port arbiter: packs up to four issue lanes into READ_PORTS RF read
// ports in rotating order, holding lanes that do not fit and stalling the issue queue.
module rf_readport_arb #(
  parameter int READ_PORTS = 6
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [3:0]  req_valid_i,
  input  logic [7:0]  req_nsrc_i,
  input  logic        flush_i,
  output logic [3:0]  go_o,
  output logic [11:0] port_base_o,
  output logic        stall_o
);

  localparam logic [4:0] RP_C = 5'(READ_PORTS);

  logic [3:0]  go_q, go_d;
  logic [11:0] base_q, base_d;
  logic [3:0]  pend_q, pend_d;
  logic [7:0]  held_q, held_d;
  logic [1:0]  ptr_q, ptr_d;

  logic        use_held_s;
  logic [3:0]  cand_s;
  logic [1:0]  cost_s [4];
  logic [2:0]  lane_base_s [4];
  logic [3:0]  grant_s;
  logic [3:0]  sum_s;
  logic        stop_s;
  logic [1:0]  lane_s;
  logic [1:0]  first_blk_s;
  logic [3:0]  pend_nxt_s;
  logic [7:0]  held_nxt_s;
  logic [11:0] base_pack_s;
  logic [1:0]  ptr_nxt_s;

  // Candidate selection, rotating allocation and next-state computation
  always_comb begin
    use_held_s  = (pend_q != 4'b0000);
    cand_s      = use_held_s ? pend_q : req_valid_i;
    grant_s     = 4'b0000;
    sum_s       = 4'd0;
    stop_s      = 1'b0;
    lane_s      = 2'd0;
    first_blk_s = ptr_q;
    held_nxt_s  = 8'h00;
    base_pack_s = 12'h000;
    for (int k = 0; k < 4; k++) begin
      lane_base_s[k] = 3'd0;
      if (use_held_s) begin
        cost_s[k] = held_q[2*k +: 2];
      end else if (req_nsrc_i[2*k +: 2] == 2'd3) begin
        cost_s[k] = 2'd2;
      end else begin
        cost_s[k] = req_nsrc_i[2*k +: 2];
      end
    end

    // Once a lane fails to fit, every later lane in rotation order stays pending.
    for (int i = 0; i < 4; i++) begin
      lane_s = ptr_q + 2'(i);
      if (cand_s[lane_s] && !stop_s) begin
        if (({1'b0, sum_s} + {3'b000, cost_s[lane_s]}) <= RP_C) begin
          grant_s[lane_s]     = 1'b1;
          lane_base_s[lane_s] = (sum_s > 4'd7) ? 3'd7 : sum_s[2:0];
          sum_s               = sum_s + {2'b00, cost_s[lane_s]};
        end else begin
          stop_s      = 1'b1;
          first_blk_s = lane_s;
        end
      end else begin
        sum_s = sum_s;
      end
    end

    pend_nxt_s = cand_s & ~grant_s;
    for (int k = 0; k < 4; k++) begin
      held_nxt_s[2*k +: 2]  = pend_nxt_s[k] ? cost_s[k] : 2'd0;
      base_pack_s[3*k +: 3] = lane_base_s[k];
    end

    if (pend_nxt_s != 4'b0000) begin
      ptr_nxt_s = first_blk_s;
    end else if (cand_s != 4'b0000) begin
      ptr_nxt_s = ptr_q + 2'd1;
    end else begin
      ptr_nxt_s = ptr_q;
    end

    if (flush_i) begin
      go_d   = 4'b0000;
      base_d = 12'h000;
      pend_d = 4'b0000;
      held_d = 8'h00;
      ptr_d  = ptr_q;
    end else begin
      go_d   = grant_s;
      base_d = base_pack_s;
      pend_d = pend_nxt_s;
      held_d = held_nxt_s;
      ptr_d  = ptr_nxt_s;
    end
  end

  // State and output registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      go_q   <= 4'b0000;
      base_q <= 12'h000;
      pend_q <= 4'b0000;
      held_q <= 8'h00;
      ptr_q  <= 2'd0;
    end else begin
      go_q   <= go_d;
      base_q <= base_d;
      pend_q <= pend_d;
      held_q <= held_d;
      ptr_q  <= ptr_d;
    end
  end

  assign go_o        = go_q;
  assign port_base_o = base_q;
  assign stall_o     = |pend_q;

endmodule

// File: tb/tb_rf_readport_arb.sv
// Directed self-checking bench for rf_readport_arb with READ_PORTS=6.
module tb_rf_readport_arb;

  logic        clk;
  logic        reset;
  logic [3:0]  req_valid_i;
  logic [7:0]  req_nsrc_i;
  logic        flush_i;
  logic [3:0]  go_o;
  logic [11:0] port_base_o;
  logic        stall_o;

  int total = 0;
  int bad   = 0;

  rf_readport_arb #(.READ_PORTS(6)) dut (
    .clk         (clk),
    .reset       (reset),
    .req_valid_i (req_valid_i),
    .req_nsrc_i  (req_nsrc_i),
    .flush_i     (flush_i),
    .go_o        (go_o),
    .port_base_o (port_base_o),
    .stall_o     (stall_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic chk_all(input string tag, input logic [3:0] g, input logic [11:0] b, input logic s);
    chk({tag, ".go"}, {8'h00, go_o}, {8'h00, g});
    chk({tag, ".base"}, port_base_o, b);
    chk({tag, ".stall"}, {11'h000, stall_o}, {11'h000, s});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    reset       = 1'b0;
    req_valid_i = 4'b0000;
    req_nsrc_i  = 8'h00;
    flush_i     = 1'b0;
    tick();
    tick();
    chk_all("reset", 4'b0000, 12'h000, 1'b0);
    @(negedge clk);
    reset = 1'b1;

    // all lanes cost 2 from ptr=0: lanes 0..2 fit, lane 3 held
    req_valid_i = 4'b1111; req_nsrc_i = 8'hAA;
    tick();
    chk_all("all2_a", 4'b0111, 12'h110, 1'b1);
    req_valid_i = 4'b0000;
    tick();
    chk_all("all2_b", 4'b1000, 12'h000, 1'b0);

    // costs 2,2,1,2: 5+2>6 holds lane 3
    req_valid_i = 4'b1111; req_nsrc_i = 8'h9A;
    tick();
    chk_all("mix_a", 4'b0111, 12'h110, 1'b1);
    req_valid_i = 4'b0000;
    tick();
    chk_all("mix_b", 4'b1000, 12'h000, 1'b0);

    // exact fit: costs 3(->2),2,2,0 -> bases 0,2,4,6; ptr 0->1
    req_valid_i = 4'b1111; req_nsrc_i = 8'h2B;
    tick();
    chk_all("exact", 4'b1111, 12'hD10, 1'b0);

    // single lane 0 from ptr=1; ptr 1->2
    req_valid_i = 4'b0001; req_nsrc_i = 8'h00;
    tick();
    chk_all("single", 4'b0001, 12'h000, 1'b0);

    // rotation from ptr=2: lanes 2,3,0 granted, lane 1 held, ptr->1
    req_valid_i = 4'b1111; req_nsrc_i = 8'hAA;
    tick();
    chk_all("rot_a", 4'b1101, 12'h404, 1'b1);
    // requests during the stall are ignored
    tick();
    chk_all("rot_b", 4'b0010, 12'h000, 1'b0);
    req_valid_i = 4'b0000;
    tick();
    chk_all("idle", 4'b0000, 12'h000, 1'b0);

    // zero-cost lanes all fit, ptr 2->3
    req_valid_i = 4'b1111; req_nsrc_i = 8'h00;
    tick();
    chk_all("zero", 4'b1111, 12'h000, 1'b0);

    // from ptr=3: lanes 3,0,1 granted, lane 2 held, ptr->2
    req_valid_i = 4'b1111; req_nsrc_i = 8'hAA;
    tick();
    chk_all("ptr3", 4'b1011, 12'h022, 1'b1);

    // flush while a lane is held, with new requests present
    flush_i = 1'b1;
    tick();
    chk_all("flush", 4'b0000, 12'h000, 1'b0);
    flush_i = 1'b0; req_valid_i = 4'b0000;
    tick();
    chk_all("post_flush", 4'b0000, 12'h000, 1'b0);

    // ptr unchanged by flush: allocation again starts at lane 2
    req_valid_i = 4'b1111;
    tick();
    chk_all("ptr_kept", 4'b1101, 12'h404, 1'b1);

    // asynchronous reset mid-cycle while a lane is pending
    #3;
    reset = 1'b0;
    #1;
    chk_all("async_rst", 4'b0000, 12'h000, 1'b0);
    req_valid_i = 4'b0000;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b1;
    req_valid_i = 4'b1111;
    tick();
    chk_all("after_rst_a", 4'b0111, 12'h110, 1'b1);
    req_valid_i = 4'b0000;
    tick();
    chk_all("after_rst_b", 4'b1000, 12'h000, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
